// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter: port index type,
// pointer reset value and the read-latency derivation.
package bram_arb_pkg;

    typedef logic port_idx_t;

    localparam port_idx_t PTR_RST = 1'b0;

    // The BRAM always registers its address; an optional output register adds a cycle.
    function automatic int unsigned rd_latency(input int unsigned pipelined);
        return 1 + pipelined;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Owns the priority pointer and produces a one-hot
// (or empty) grant vector; grants are forced low while reset is asserted.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    port_idx_t ptr_q;
    port_idx_t ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (!rst_i) begin
            if (req_i[0] && (!req_i[1] || (ptr_q == 1'b0))) begin
                gnt_o = 2'b01;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
            end
        end
        // The port just served loses priority; an idle cycle keeps the pointer.
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-ported BRAM between two requesters. One access per cycle,
// read responses tagged through an L-deep pipeline matching the BRAM latency.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PIPELINED  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0_VALID,
    input  logic                  REQ0_WE,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic                  REQ1_WE,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
    output logic                  REQ1_READY,
    output logic                  RSP0_VALID,
    output logic [DATA_WIDTH-1:0] RSP0_DATA,
    output logic                  RSP1_VALID,
    output logic [DATA_WIDTH-1:0] RSP1_DATA,
    output logic                  BRAM_EN,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    input  logic [DATA_WIDTH-1:0] BRAM_DO
);

    localparam int unsigned L = rd_latency(PIPELINED);

    logic [1:0]   gnt;
    logic [L-1:0] vld_q;
    logic [L-1:0] vld_d;
    port_idx_t    tag_q [L];
    port_idx_t    tag_d [L];

    rr_arb2 u_arb (
        .clk_i (CLK),
        .rst_i (RST),
        .req_i ({REQ1_VALID, REQ0_VALID}),
        .gnt_o (gnt)
    );

    always_comb begin
        REQ0_READY = gnt[0];
        REQ1_READY = gnt[1];
        BRAM_EN    = 1'b0;
        BRAM_WE    = 1'b0;
        BRAM_ADDR  = '0;
        BRAM_DI    = '0;
        if (gnt[0]) begin
            BRAM_EN   = 1'b1;
            BRAM_WE   = REQ0_WE;
            BRAM_ADDR = REQ0_ADDR;
            BRAM_DI   = REQ0_WDATA;
        end else if (gnt[1]) begin
            BRAM_EN   = 1'b1;
            BRAM_WE   = REQ1_WE;
            BRAM_ADDR = REQ1_ADDR;
            BRAM_DI   = REQ1_WDATA;
        end
    end

    // Only reads occupy a response slot; writes enter as bubbles.
    always_comb begin
        vld_d    = '0;
        tag_d[0] = gnt[1];
        vld_d[0] = (gnt[0] & ~REQ0_WE) | (gnt[1] & ~REQ1_WE);
        for (int i = 1; i < L; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q <= '0;
            for (int i = 0; i < L; i++) begin
                tag_q[i] <= PTR_RST;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < L; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign RSP0_VALID = vld_q[L-1] & (tag_q[L-1] == 1'b0);
    assign RSP1_VALID = vld_q[L-1] & (tag_q[L-1] == 1'b1);
    assign RSP0_DATA  = BRAM_DO;
    assign RSP1_DATA  = BRAM_DO;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: one instance per latency (PIPELINED=0/1) driven by
// shared requests, each with its own BRAM model and expected-response queue.
module tb_bram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared request inputs
  logic          v0 = 0, we0 = 0, v1 = 0, we1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic          rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], en [2], bwe [2];
  logic [AW-1:0] baddr [2];
  logic [DW-1:0] bdi [2], bdo [2], rd0 [2], rd1 [2];

  generate
    for (genvar g = 0; g < 2; g++) begin : gen_dut
      logic [DW-1:0] mem [1<<AW];
      logic [DW-1:0] do1, do2;

      bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(g)) u_dut (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_WE(we0), .REQ0_ADDR(a0), .REQ0_WDATA(d0), .REQ0_READY(rdy0[g]),
        .REQ1_VALID(v1), .REQ1_WE(we1), .REQ1_ADDR(a1), .REQ1_WDATA(d1), .REQ1_READY(rdy1[g]),
        .RSP0_VALID(rv0[g]), .RSP0_DATA(rd0[g]), .RSP1_VALID(rv1[g]), .RSP1_DATA(rd1[g]),
        .BRAM_EN(en[g]), .BRAM_WE(bwe[g]), .BRAM_ADDR(baddr[g]), .BRAM_DI(bdi[g]),
        .BRAM_DO(bdo[g])
      );

      // BRAM model sitting beside the arbiter
      always @(posedge clk) begin
        if (en[g]) begin
          if (bwe[g]) mem[baddr[g]] <= bdi[g];
          do1 <= mem[baddr[g]];
        end
        do2 <= do1;
      end
      assign bdo[g] = (g == 0) ? do1 : do2;
    end
  endgenerate

  // scoreboard state and reference model
  int checks = 0;
  int errors = 0;
  exp_t exp_q [2][$];
  logic [DW-1:0] ref_mem [16];
  int ptr_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // request-side checker: expected grant and BRAM drive from the arbitration rule
  int            eg;
  logic          sel_we;
  logic [AW-1:0] sel_a;
  logic [DW-1:0] sel_d;
  exp_t          e_new;
  always @(negedge clk) begin
    if (rst) begin
      ptr_m = 0;
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("ready_in_reset[%0d]", g), {rdy0[g], rdy1[g]}, 0);
        chk($sformatf("en_in_reset[%0d]", g), {en[g], bwe[g]}, 0);
      end
    end else begin
      eg = -1;
      if (v0 && (!v1 || ptr_m == 0)) eg = 0;
      else if (v1) eg = 1;
      sel_we = (eg == 0) ? we0 : (eg == 1) ? we1 : 1'b0;
      sel_a  = (eg == 0) ? a0  : (eg == 1) ? a1  : '0;
      sel_d  = (eg == 0) ? d0  : (eg == 1) ? d1  : '0;
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("ready0[%0d]", g), rdy0[g], eg == 0);
        chk($sformatf("ready1[%0d]", g), rdy1[g], eg == 1);
        chk($sformatf("bram_en[%0d]", g), en[g], eg >= 0);
        chk($sformatf("bram_we[%0d]", g), bwe[g], sel_we);
        chk($sformatf("bram_addr[%0d]", g), baddr[g], sel_a);
        chk($sformatf("bram_di[%0d]", g), bdi[g], sel_d);
      end
      chk("ptr[0]", gen_dut[0].u_dut.u_arb.ptr_q, ptr_m[0]);
      chk("ptr[1]", gen_dut[1].u_dut.u_arb.ptr_q, ptr_m[0]);
      if (eg >= 0) begin
        if (sel_we) begin
          ref_mem[sel_a[3:0]] = sel_d;
        end else begin
          for (int g = 0; g < 2; g++) begin
            e_new.port = eg;
            e_new.data = ref_mem[sel_a[3:0]];
            e_new.due  = cyc + 1 + g;
            exp_q[g].push_back(e_new);
          end
        end
        ptr_m = 1 - eg;
      end
    end
  end

  // response monitor
  exp_t e_pop;
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        chk($sformatf("rsp_in_reset[%0d]", g), {rv0[g], rv1[g]}, 0);
        exp_q[g].delete();
      end else if (rv0[g] || rv1[g]) begin
        chk($sformatf("rsp_onehot[%0d]", g), rv0[g] & rv1[g], 0);
        if (exp_q[g].size() == 0) begin
          chk($sformatf("rsp_unexpected[%0d]", g), 1, 0);
        end else begin
          e_pop = exp_q[g].pop_front();
          chk($sformatf("rsp_port[%0d]", g), rv1[g], e_pop.port);
          chk($sformatf("rsp0_data[%0d]", g), rd0[g], e_pop.data);
          chk($sformatf("rsp1_data[%0d]", g), rd1[g], e_pop.data);
          chk($sformatf("rsp_cycle[%0d]", g), cyc, e_pop.due);
        end
      end else if (exp_q[g].size() > 0 && exp_q[g][0].due <= cyc) begin
        chk($sformatf("rsp_missing[%0d]", g), 0, 1);
        void'(exp_q[g].pop_front());
      end
    end
  end

  // driver tasks
  task automatic step(input logic v0_, input logic we0_, input int a0_, input logic [DW-1:0] d0_,
                      input logic v1_, input logic we1_, input int a1_, input logic [DW-1:0] d1_);
    v0 = v0_; we0 = we0_; a0 = AW'(a0_); d0 = d0_;
    v1 = v1_; we1 = we1_; a1 = AW'(a1_); d1 = d1_;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  logic g0, g1;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // fill every address used by the bench
    for (int i = 0; i < 16; i++) step(1, 1, i, $urandom, 0, 0, 0, '0);
    idle(3);

    // write then immediate read of the same word from the other port
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, '0);
    step(0, 0, 0, '0, 1, 0, 5, '0);
    idle(3);

    // reset, then both ports reading continuously
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    repeat (6) step(1, 0, 1, '0, 1, 0, 2, '0);
    idle(2);

    // back-to-back port-0 reads
    for (int i = 0; i < 4; i++) step(1, 0, i, '0, 0, 0, 0, '0);
    idle(3);

    // port 0 alone, then contention: port 1 must win first
    repeat (3) step(1, 1, $urandom_range(0, 15), $urandom, 0, 0, 0, '0);
    step(1, 0, 7, '0, 1, 0, 8, '0);
    step(1, 0, 7, '0, 1, 0, 9, '0);
    idle(2);

    // port-1 read discarded by a reset pulse in the next cycle
    step(0, 0, 0, '0, 1, 0, 3, '0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    step(1, 0, 4, '0, 1, 0, 6, '0);
    step(0, 0, 0, '0, 1, 0, 6, '0);
    idle(3);

    // random traffic; a request is held until accepted
    v0 = 0; v1 = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      g0 = rdy0[0];
      g1 = rdy1[0];
      @(posedge clk);
      #1;
      rst = (n == 200);
      if (!v0 || g0) begin
        v0 = ($urandom_range(0, 3) != 0);
        we0 = 1'($urandom_range(0, 1));
        a0 = AW'($urandom_range(0, 15));
        d0 = $urandom;
      end
      if (!v1 || g1) begin
        v1 = ($urandom_range(0, 3) != 0);
        we1 = 1'($urandom_range(0, 1));
        a1 = AW'($urandom_range(0, 15));
        d1 = $urandom;
      end
    end
    rst = 1'b0;
    idle(6);

    chk("drain[0]", exp_q[0].size(), 0);
    chk("drain[1]", exp_q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
